// File: rtl/qei_pkg.sv
// Shared definitions for the multi-channel quadrature encoder interface:
// Gray-code AB states, step decoding and bus slicing helpers.
package qei_pkg;

    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_10 = 2'b10;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_01 = 2'b01;

    localparam int PIN_Z = 0;
    localparam int PIN_B = 1;
    localparam int PIN_A = 2;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_UP,
        STEP_DOWN,
        STEP_ILLEGAL
    } step_t;

    // Next AB state when A leads B (forward rotation).
    function automatic logic [1:0] ab_fwd(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            AB_00:   nxt = AB_10;
            AB_10:   nxt = AB_11;
            AB_11:   nxt = AB_01;
            default: nxt = AB_00;
        endcase
        return nxt;
    endfunction

    // Any two-bit change lands in the final else branch.
    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        step_t st;
        if (cur == prev)
            st = STEP_HOLD;
        else if (cur == ab_fwd(prev))
            st = STEP_UP;
        else if (prev == ab_fwd(cur))
            st = STEP_DOWN;
        else
            st = STEP_ILLEGAL;
        return st;
    endfunction

    function automatic int slice_lo(input int chan, input int width);
        return chan * width;
    endfunction

endpackage

// File: rtl/qei_multi_if.sv
// Bus bundle between the CPU-side register block and the encoder channels.
interface qei_multi_if #(
    parameter int CHANNELS = 3,
    parameter int CNT_W    = 32
);
    logic [3*CHANNELS-1:0]     enc_abz;
    logic [CHANNELS-1:0]       clr;
    logic [CHANNELS-1:0]       idx_zero_en;
    logic                      snap;
    logic                      err_clr;
    logic [CHANNELS*CNT_W-1:0] count;
    logic [CHANNELS*CNT_W-1:0] snap_count;
    logic [CHANNELS*CNT_W-1:0] idx_pos;
    logic [CHANNELS-1:0]       idx_seen;
    logic [CHANNELS-1:0]       err;

    modport master (
        output enc_abz, clr, idx_zero_en, snap, err_clr,
        input  count, snap_count, idx_pos, idx_seen, err
    );

    modport slave (
        input  enc_abz, clr, idx_zero_en, snap, err_clr,
        output count, snap_count, idx_pos, idx_seen, err
    );
endinterface

// File: rtl/qei_channel.sv
// One encoder channel: synchroniser, glitch filter, x4 decode, count,
// index latch, illegal-transition flag and snapshot register.
module qei_channel
    import qei_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       abz_raw,
    input  logic             clr,
    input  logic             idx_zero_en,
    input  logic             snap,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] snap_count,
    output logic [CNT_W-1:0] idx_pos,
    output logic             idx_seen,
    output logic             err
);

    localparam logic [7:0] FILT_LAST = 8'(FILT_LEN - 1);

    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       filt;
    logic [2:0]       filt_prev;
    logic [7:0]       filt_cnt [3];
    step_t            step;
    logic             idx_rise;
    logic [CNT_W-1:0] count_step;
    logic [CNT_W-1:0] count_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= abz_raw;
            sync2 <= sync1;
        end
    end

    // A pin only moves after FILT_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= '0;
            for (int p = 0; p < 3; p++)
                filt_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (sync2[p] == filt[p]) begin
                    filt_cnt[p] <= '0;
                end else if (filt_cnt[p] == FILT_LAST) begin
                    filt[p]     <= sync2[p];
                    filt_cnt[p] <= '0;
                end else begin
                    filt_cnt[p] <= filt_cnt[p] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        step       = decode_step(filt_prev[PIN_A:PIN_B], filt[PIN_A:PIN_B]);
        idx_rise   = filt[PIN_Z] & ~filt_prev[PIN_Z];
        count_step = count;
        case (step)
            STEP_UP:   count_step = count + CNT_W'(1);
            STEP_DOWN: count_step = count - CNT_W'(1);
            default:   count_step = count;
        endcase
        if (clr)
            count_next = '0;
        else if (idx_rise && idx_zero_en)
            count_next = '0;
        else
            count_next = count_step;
    end

    // idx_pos records the stepped count even when the index zeroes the live count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_prev  <= '0;
            count      <= '0;
            snap_count <= '0;
            idx_pos    <= '0;
            idx_seen   <= 1'b0;
            err        <= 1'b0;
        end else begin
            filt_prev <= filt;
            count     <= count_next;
            if (snap)
                snap_count <= count;
            if (idx_rise)
                idx_pos <= count_step;
            if (clr)
                idx_seen <= 1'b0;
            else if (idx_rise)
                idx_seen <= 1'b1;
            if (step == STEP_ILLEGAL)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

endmodule

// File: rtl/qei_multi.sv
// Multi-channel quadrature encoder interface: one qei_channel per axis,
// all sharing the snapshot strobe so captured positions are coherent.
module qei_multi
    import qei_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 4
) (
    input logic        clk,
    input logic        reset_n,
    qei_multi_if.slave bus
);

    logic [CHANNELS*CNT_W-1:0] count_bus;
    logic [CHANNELS*CNT_W-1:0] snap_bus;
    logic [CHANNELS*CNT_W-1:0] idx_bus;
    logic [CHANNELS-1:0]       seen_bus;
    logic [CHANNELS-1:0]       err_bus;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        qei_channel #(
            .CNT_W    (CNT_W),
            .FILT_LEN (FILT_LEN)
        ) u_channel (
            .clk         (clk),
            .reset_n     (reset_n),
            .abz_raw     (bus.enc_abz[3*c +: 3]),
            .clr         (bus.clr[c]),
            .idx_zero_en (bus.idx_zero_en[c]),
            .snap        (bus.snap),
            .err_clr     (bus.err_clr),
            .count       (count_bus[slice_lo(c, CNT_W) +: CNT_W]),
            .snap_count  (snap_bus[slice_lo(c, CNT_W) +: CNT_W]),
            .idx_pos     (idx_bus[slice_lo(c, CNT_W) +: CNT_W]),
            .idx_seen    (seen_bus[c]),
            .err         (err_bus[c])
        );
    end

    assign bus.count      = count_bus;
    assign bus.snap_count = snap_bus;
    assign bus.idx_pos    = idx_bus;
    assign bus.idx_seen   = seen_bus;
    assign bus.err        = err_bus;

endmodule

// File: tb/tb_qei_multi.sv
// Directed bench for qei_multi: a 3-channel 32-bit instance plus a narrow
// 4-bit, FILT_LEN=1 instance used to exercise signed wrap-around.
module tb_qei_multi;

    localparam int CH  = 3;
    localparam int W   = 32;
    localparam int FL  = 4;
    localparam int LAT = FL + 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    logic [1:0] ab_st [CH];
    logic       z_st  [CH];

    always #10 clk = ~clk;

    qei_multi_if #(.CHANNELS(CH), .CNT_W(W)) bus ();
    qei_multi_if #(.CHANNELS(1),  .CNT_W(4)) bus_w ();

    qei_multi #(.CHANNELS(CH), .CNT_W(W), .FILT_LEN(FL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    qei_multi #(.CHANNELS(1), .CNT_W(4), .FILT_LEN(1)) dut_w (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_w)
    );

    function automatic logic [1:0] next_fwd(input logic [1:0] ab);
        logic [1:0] r;
        case (ab)
            2'b00:   r = 2'b10;
            2'b10:   r = 2'b11;
            2'b11:   r = 2'b01;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] next_rev(input logic [1:0] ab);
        logic [1:0] r;
        case (ab)
            2'b00:   r = 2'b01;
            2'b01:   r = 2'b11;
            2'b11:   r = 2'b10;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] ch_count(input int c);
        return bus.count[c*W +: W];
    endfunction

    function automatic logic [W-1:0] ch_snap(input int c);
        return bus.snap_count[c*W +: W];
    endfunction

    function automatic logic [W-1:0] ch_idx(input int c);
        return bus.idx_pos[c*W +: W];
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_pins(input int c);
        bus.enc_abz[3*c +: 3] = {ab_st[c], z_st[c]};
    endtask

    task automatic fwd_steps(input int c, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            ab_st[c] = next_fwd(ab_st[c]);
            drive_pins(c);
            cycles(gap);
        end
    endtask

    task automatic rev_steps(input int c, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            ab_st[c] = next_rev(ab_st[c]);
            drive_pins(c);
            cycles(gap);
        end
    endtask

    task automatic test_reset;
        bus.enc_abz       = '0;
        bus.clr           = '0;
        bus.idx_zero_en   = '0;
        bus.snap          = 1'b0;
        bus.err_clr       = 1'b0;
        bus_w.enc_abz     = '0;
        bus_w.clr         = '0;
        bus_w.idx_zero_en = '0;
        bus_w.snap        = 1'b0;
        bus_w.err_clr     = 1'b0;
        for (int c = 0; c < CH; c++) begin
            ab_st[c] = 2'b00;
            z_st[c]  = 1'b0;
        end
        cycles(1);
        reset_n = 1'b0;
        cycles(3);
        checks++;
        if (bus.count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_count got %h want 0", bus.count);
        end
        checks++;
        if (bus.snap_count !== '0 || bus.idx_pos !== '0) begin
            errors++;
            $display("[TB] FAIL reset_regs got snap=%h idx=%h want 0", bus.snap_count, bus.idx_pos);
        end
        checks++;
        if (bus.idx_seen !== '0 || bus.err !== '0) begin
            errors++;
            $display("[TB] FAIL reset_flags got seen=%b err=%b want 0", bus.idx_seen, bus.err);
        end
        checks++;
        if (bus_w.count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_narrow got %h want 0", bus_w.count);
        end
        reset_n = 1'b1;
        cycles(2);
    endtask

    // Each pin edge must take exactly LAT cycles to reach the count.
    task automatic test_forward;
        for (int i = 0; i < 32; i++) begin
            ab_st[0] = next_fwd(ab_st[0]);
            drive_pins(0);
            cycles(LAT - 1);
            checks++;
            if (ch_count(0) !== W'(i)) begin
                errors++;
                $display("[TB] FAIL fwd_early%0d got %0d want %0d", i, ch_count(0), i);
            end
            cycles(1);
            checks++;
            if (ch_count(0) !== W'(i + 1)) begin
                errors++;
                $display("[TB] FAIL fwd_step%0d got %0d want %0d", i, ch_count(0), i + 1);
            end
            cycles(10 - LAT);
        end
        checks++;
        if (ch_count(1) !== '0 || ch_count(2) !== '0) begin
            errors++;
            $display("[TB] FAIL fwd_others got ch1=%h ch2=%h want 0", ch_count(1), ch_count(2));
        end
    endtask

    task automatic test_reverse;
        rev_steps(1, 12, 10);
        checks++;
        if (ch_count(1) !== 32'hFFFF_FFF4) begin
            errors++;
            $display("[TB] FAIL reverse got %h want fffffff4", ch_count(1));
        end
        checks++;
        if (ch_count(0) !== 32'd32) begin
            errors++;
            $display("[TB] FAIL reverse_ch0 got %0d want 32", ch_count(0));
        end
    endtask

    task automatic test_wrap;
        logic [1:0] ab;
        ab = 2'b00;
        for (int i = 0; i < 7; i++) begin
            ab = next_fwd(ab);
            bus_w.enc_abz = {ab, 1'b0};
            cycles(6);
        end
        checks++;
        if (bus_w.count !== 4'h7) begin
            errors++;
            $display("[TB] FAIL wrap_pre got %h want 7", bus_w.count);
        end
        ab = next_fwd(ab);
        bus_w.enc_abz = {ab, 1'b0};
        cycles(6);
        checks++;
        if (bus_w.count !== 4'h8) begin
            errors++;
            $display("[TB] FAIL wrap_up got %h want 8", bus_w.count);
        end
        ab = next_rev(ab);
        bus_w.enc_abz = {ab, 1'b0};
        cycles(6);
        checks++;
        if (bus_w.count !== 4'h7) begin
            errors++;
            $display("[TB] FAIL wrap_down got %h want 7", bus_w.count);
        end
    endtask

    task automatic test_glitch;
        bus.enc_abz[2] = 1'b1;
        cycles(3);
        bus.enc_abz[2] = 1'b0;
        cycles(10);
        checks++;
        if (ch_count(0) !== 32'd32 || bus.err[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch3 got cnt=%0d err=%b want 32/0", ch_count(0), bus.err[0]);
        end
        bus.enc_abz[2] = 1'b1;
        cycles(4);
        bus.enc_abz[2] = 1'b0;
        cycles(4);
        checks++;
        if (ch_count(0) !== 32'd33) begin
            errors++;
            $display("[TB] FAIL glitch4_up got %0d want 33", ch_count(0));
        end
        cycles(4);
        checks++;
        if (ch_count(0) !== 32'd32 || bus.err[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch4_back got cnt=%0d err=%b want 32/0", ch_count(0), bus.err[0]);
        end
    endtask

    task automatic test_illegal;
        ab_st[0] = 2'b11;
        drive_pins(0);
        cycles(LAT + 2);
        checks++;
        if (bus.err[0] !== 1'b1 || ch_count(0) !== 32'd32) begin
            errors++;
            $display("[TB] FAIL illegal got err=%b cnt=%0d want 1/32", bus.err[0], ch_count(0));
        end
        bus.err_clr = 1'b1;
        cycles(1);
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_clr got %b want 0", bus.err[0]);
        end
        ab_st[0] = 2'b00;
        drive_pins(0);
        cycles(LAT - 1);
        bus.err_clr = 1'b1;
        cycles(1);
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err[0] !== 1'b1 || ch_count(0) !== 32'd32) begin
            errors++;
            $display("[TB] FAIL err_race got err=%b cnt=%0d want 1/32", bus.err[0], ch_count(0));
        end
        bus.err_clr = 1'b1;
        cycles(1);
        bus.err_clr = 1'b0;
    endtask

    task automatic test_index;
        bus.clr[1] = 1'b1;
        cycles(1);
        bus.clr[1] = 1'b0;
        checks++;
        if (ch_count(1) !== '0 || ch_count(0) !== 32'd32) begin
            errors++;
            $display("[TB] FAIL clr1 got ch1=%0d ch0=%0d want 0/32", ch_count(1), ch_count(0));
        end
        bus.idx_zero_en[1] = 1'b1;
        fwd_steps(1, 57, 8);
        checks++;
        if (ch_count(1) !== 32'd57) begin
            errors++;
            $display("[TB] FAIL idx_pre got %0d want 57", ch_count(1));
        end
        ab_st[1] = next_fwd(ab_st[1]);
        z_st[1]  = 1'b1;
        drive_pins(1);
        cycles(10);
        checks++;
        if (ch_count(1) !== '0 || ch_idx(1) !== 32'd58 || bus.idx_seen[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idx_zero got cnt=%0d pos=%0d seen=%b want 0/58/1",
                     ch_count(1), ch_idx(1), bus.idx_seen[1]);
        end
        bus.idx_zero_en[1] = 1'b0;
        z_st[1] = 1'b0;
        drive_pins(1);
        cycles(10);
        fwd_steps(1, 58, 8);
        ab_st[1] = next_fwd(ab_st[1]);
        z_st[1]  = 1'b1;
        drive_pins(1);
        cycles(10);
        checks++;
        if (ch_count(1) !== 32'd59 || ch_idx(1) !== 32'd59) begin
            errors++;
            $display("[TB] FAIL idx_keep got cnt=%0d pos=%0d want 59/59", ch_count(1), ch_idx(1));
        end
        checks++;
        if (bus.idx_seen !== 3'b010) begin
            errors++;
            $display("[TB] FAIL idx_seen_mask got %b want 010", bus.idx_seen);
        end
    endtask

    task automatic test_snap_clr;
        bus.clr[0] = 1'b1;
        cycles(1);
        bus.clr[0] = 1'b0;
        fwd_steps(0, 9, 8);
        ab_st[0] = next_fwd(ab_st[0]);
        drive_pins(0);
        cycles(LAT - 1);
        bus.snap = 1'b1;
        cycles(1);
        bus.snap = 1'b0;
        checks++;
        if (ch_snap(0) !== 32'd9 || ch_count(0) !== 32'd10) begin
            errors++;
            $display("[TB] FAIL snap got snap=%0d cnt=%0d want 9/10", ch_snap(0), ch_count(0));
        end
        checks++;
        if (ch_snap(1) !== 32'd59) begin
            errors++;
            $display("[TB] FAIL snap_ch1 got %0d want 59", ch_snap(1));
        end
        fwd_steps(2, 3, 8);
        checks++;
        if (ch_count(2) !== 32'd3) begin
            errors++;
            $display("[TB] FAIL ch2_steps got %0d want 3", ch_count(2));
        end
        z_st[2] = 1'b1;
        drive_pins(2);
        cycles(LAT - 1);
        bus.clr[2] = 1'b1;
        cycles(1);
        bus.clr[2] = 1'b0;
        checks++;
        if (ch_count(2) !== '0 || bus.idx_seen[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_vs_idx got cnt=%0d seen=%b want 0/0", ch_count(2), bus.idx_seen[2]);
        end
        z_st[2] = 1'b0;
        drive_pins(2);
        cycles(10);
        z_st[2] = 1'b1;
        drive_pins(2);
        cycles(10);
        checks++;
        if (bus.idx_seen[2] !== 1'b1 || ch_idx(2) !== '0) begin
            errors++;
            $display("[TB] FAIL idx_after_clr got seen=%b pos=%0d want 1/0", bus.idx_seen[2], ch_idx(2));
        end
    endtask

    task automatic test_reset_midop;
        #4;
        reset_n = 1'b0;
        #2;
        checks++;
        if (bus.count !== '0 || bus.idx_pos !== '0 || bus.idx_seen !== '0 || bus.snap_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_midop got cnt=%h seen=%b want 0", bus.count, bus.idx_seen);
        end
    endtask

    initial begin
        test_reset;
        test_forward;
        test_reverse;
        test_wrap;
        test_glitch;
        test_illegal;
        test_index;
        test_snap_clr;
        test_reset_midop;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
